dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline memory stage and the data-memory responder.
// Pure wiring, no latency; the pipeline (master) holds its request while stall is high.
// rd_count/wr_count are always present and read zero unless DMEM_ACCESS_CNT_EN is defined.
interface dmem_responder_if #(
   parameter int DATA_W = 32
);
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              done;
   logic              ready;
   logic              stall;
   logic              addr_err;
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;

   modport master (
      output mem_read, mem_write, addr, wdata,
      input  rdata, rvalid, done, ready, stall, addr_err, rd_count, wr_count
   );

   modport slave (
      input  mem_read, mem_write, addr, wdata,
      output rdata, rvalid, done, ready, stall, addr_err, rd_count, wr_count
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with WAIT_STATES busy cycles; optional access counters under DMEM_ACCESS_CNT_EN.
// Latency: request sample to rdata/rvalid is WAIT_STATES+1 cycles; one access per WAIT_STATES+2 cycles.
// Backpressure: stall holds the pipeline from request presentation through BUSY; requests outside IDLE are ignored.
module dmem_responder #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic [31:0]       lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_rd, lat_wr;

   logic              req, sample, access;
   logic [31:0]       acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              acc_rd, acc_wr;
   logic              in_range, conflict;
   logic              rd_ok, rd_oor, wr_ok, wr_commit;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   assign req    = bus.mem_read | bus.mem_write;
   assign sample = (state == IDLE) && req;
   assign access = (sample && (WS == 4'd0)) || ((state == BUSY) && (cnt == 4'd1));

   // With zero wait states the access edge is also the sample edge, so use the live request.
   assign acc_addr  = (state == IDLE) ? bus.addr      : lat_addr;
   assign acc_wdata = (state == IDLE) ? bus.wdata     : lat_wdata;
   assign acc_rd    = (state == IDLE) ? bus.mem_read  : lat_rd;
   assign acc_wr    = (state == IDLE) ? bus.mem_write : lat_wr;

   assign in_range  = (acc_addr[31:ADDR_W] == '0);
   assign conflict  = acc_rd & acc_wr;
   assign rd_ok     = access & acc_rd & ~acc_wr & in_range;
   assign rd_oor    = access & acc_rd & ~acc_wr & ~in_range;
   assign wr_ok     = access & acc_wr & ~acc_rd & in_range;
   assign wr_commit = wr_ok & reset;

   assign bus.ready = (state == IDLE);
   assign bus.stall = sample | (state == BUSY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = (WS == 4'd0) ? RESP : BUSY;
         BUSY:    if (cnt == 4'd1) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
      end else begin
         if (sample) begin
            cnt       <= WS;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_rd    <= bus.mem_read;
            lat_wr    <= bus.mem_write;
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Response flags are registered at the access edge so they are high exactly for the RESP cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rdata    <= '0;
         bus.rvalid   <= 1'b0;
         bus.done     <= 1'b0;
         bus.addr_err <= 1'b0;
      end else begin
         bus.rvalid   <= rd_ok | rd_oor;
         bus.done     <= access;
         bus.addr_err <= access & (conflict | ~in_range);
         if (rd_ok) begin
            bus.rdata <= mem[acc_addr[ADDR_W-1:0]];
         end else if (rd_oor) begin
            bus.rdata <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_commit) begin
         mem[acc_addr[ADDR_W-1:0]] <= acc_wdata;
      end
   end

`ifdef DMEM_ACCESS_CNT_EN
   logic [15:0] rd_cnt, wr_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (rd_ok && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
         if (wr_ok && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
      end
   end

   assign bus.rd_count = rd_cnt;
   assign bus.wr_count = wr_cnt;
`else
   assign bus.rd_count = '0;
   assign bus.wr_count = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a per-cycle timeline model of the expected outputs,
// checked every cycle, plus literal expectations for each scenario.
module tb_dmem_responder;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int W  = 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_W(DW)) bus ();

   dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit          stall;
      bit          busy;
      bit          done;
      bit          rv;
      bit          err;
      bit          rupd;
      logic [31:0] rval;
      bit          wc;
      int          wa;
      logic [31:0] wd;
      bit          rinc;
      bit          winc;
   } cyc_exp_t;

   cyc_exp_t    sched [int];
   logic [31:0] mdl [int];
   logic [31:0] exp_rdata = '0;
   int          exp_rdc = 0, exp_wrc = 0;
   int          n_cmp = 0, n_bad = 0;
   int          cyc = 0;
   bit          chk_en = 1'b0;
   int          done_cnt = 0, rv_cnt = 0, stall_cnt = 0;
   cyc_exp_t    ce;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic cyc_exp_t get_e(input int k);
      cyc_exp_t e;
      e = '{default: 0};
      if (sched.exists(k)) e = sched[k];
      return e;
   endfunction

   // Model of one access sampled at the end of cycle c.
   task automatic sched_access(input int c, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d);
      cyc_exp_t e;
      bit       inr;
      inr = (a < 32'(2**AW));
      for (int k = c; k <= c + W; k++) begin
         e = get_e(k); e.stall = 1'b1; sched[k] = e;
      end
      for (int k = c + 1; k <= c + W + 1; k++) begin
         e = get_e(k); e.busy = 1'b1; sched[k] = e;
      end
      e = get_e(c + W + 1);
      e.done = 1'b1;
      e.err  = (rd & wr) | !inr;
      e.rv   = rd & !wr;
      e.rupd = e.rv;
      e.rval = (inr && mdl.exists(int'(a))) ? mdl[int'(a)] : 32'h0;
      e.wc   = wr & !rd & inr;
      e.wa   = int'(a);
      e.wd   = d;
      e.rinc = e.rv & inr;
      e.winc = e.wc;
      sched[c + W + 1] = e;
   endtask

   task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.addr      = a;
      bus.wdata     = d;
      sched_access(cyc, rd, wr, a, d);
      repeat (W + 1) @(negedge clk);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   always @(negedge clk) begin
      #2;
      if (chk_en) begin
         ce = get_e(cyc);
         if (ce.wc) mdl[ce.wa] = ce.wd;
         if (ce.rupd) exp_rdata = ce.rval;
`ifdef DMEM_ACCESS_CNT_EN
         if (ce.rinc && exp_rdc < 65535) exp_rdc++;
         if (ce.winc && exp_wrc < 65535) exp_wrc++;
`endif
         chk("stall",    32'(bus.stall),    32'(ce.stall));
         chk("ready",    32'(bus.ready),    32'(!ce.busy));
         chk("done",     32'(bus.done),     32'(ce.done));
         chk("rvalid",   32'(bus.rvalid),   32'(ce.rv));
         chk("addr_err", 32'(bus.addr_err), 32'(ce.err));
         chk("rdata",    bus.rdata,         exp_rdata);
         chk("rd_count", 32'(bus.rd_count), 32'(exp_rdc));
         chk("wr_count", 32'(bus.wr_count), 32'(exp_wrc));
         if (bus.done)   done_cnt++;
         if (bus.rvalid) rv_cnt++;
         if (bus.stall)  stall_cnt++;
      end
   end

   logic [31:0] wr_a [5] = '{32'd8, 32'd9, 32'd10, 32'd57, 32'd58};
   logic [31:0] wr_d [5] = '{32'd37, 32'd39, 32'd43, 32'd55, 32'd1};

   initial begin
      int d0, r0, s0, c0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.addr      = '0;
      bus.wdata     = '0;
      #1 reset = 1'b0;
      #20 reset = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      #3;
      chk("t1_ready",  32'(bus.ready),  32'd1);
      chk("t1_stall",  32'(bus.stall),  32'd0);
      chk("t1_rdata",  bus.rdata,       32'd0);
      chk("t1_rvalid", 32'(bus.rvalid), 32'd0);
      chk("t1_done",   32'(bus.done),   32'd0);

      // Writes
      d0 = done_cnt; r0 = rv_cnt;
      for (int i = 0; i < 5; i++) issue(1'b0, 1'b1, wr_a[i], wr_d[i]);
      @(negedge clk); #3;
      chk("t2_done_pulses", 32'(done_cnt - d0), 32'd5);
      chk("t2_rvalid_none", 32'(rv_cnt - r0),   32'd0);

      // Reads back
      for (int i = 0; i < 5; i++) begin
         s0 = stall_cnt;
         issue(1'b1, 1'b0, wr_a[i], 32'h0);
         #3;
         chk("t3_rdata",  bus.rdata,                 wr_d[i]);
         chk("t3_rvalid", 32'(bus.rvalid),           32'd1);
         chk("t3_stall_cycles", 32'(stall_cnt - s0), 32'd2);
      end

      // Out-of-range read, then an in-range read
      issue(1'b1, 1'b0, 32'h1000, 32'h0);
      #3;
      chk("t4_rdata",    bus.rdata,         32'd0);
      chk("t4_rvalid",   32'(bus.rvalid),   32'd1);
      chk("t4_addr_err", 32'(bus.addr_err), 32'd1);
      issue(1'b1, 1'b0, 32'd8, 32'h0);
      #3;
      chk("t4_rd8", bus.rdata, 32'd37);

      // Conflicting read+write
      issue(1'b1, 1'b1, 32'd9, 32'd99);
      #3;
      chk("t5_addr_err", 32'(bus.addr_err), 32'd1);
      chk("t5_done",     32'(bus.done),     32'd1);
      chk("t5_rvalid",   32'(bus.rvalid),   32'd0);
      chk("t5_rdata_hold", bus.rdata,       32'd37);
      issue(1'b1, 1'b0, 32'd9, 32'h0);
      #3;
      chk("t5_rd9", bus.rdata, 32'd39);

      // Write aborted by reset during BUSY
      @(negedge clk);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b1;
      bus.addr      = 32'd10;
      bus.wdata     = 32'd77;
      sched_access(cyc, 1'b0, 1'b1, 32'd10, 32'd77);
      @(negedge clk);
      reset = 1'b0;
      bus.mem_write = 1'b0;
      begin
         int keys [$];
         foreach (sched[k]) if (k >= cyc) keys.push_back(k);
         foreach (keys[j]) sched.delete(keys[j]);
      end
      exp_rdata = '0;
      exp_rdc   = 0;
      exp_wrc   = 0;
      c0 = cyc;
      #3;
      chk("t6_ready",    32'(bus.ready),    32'd1);
      chk("t6_stall",    32'(bus.stall),    32'd0);
      chk("t6_rdata",    bus.rdata,         32'd0);
      chk("t6_rvalid",   32'(bus.rvalid),   32'd0);
      chk("t6_done",     32'(bus.done),     32'd0);
      chk("t6_addr_err", 32'(bus.addr_err), 32'd0);
      chk("t6_rd_count", 32'(bus.rd_count), 32'd0);
      chk("t6_wr_count", 32'(bus.wr_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #3;
      chk("t6_ready_after", 32'(bus.ready), 32'd1);
      chk("t6_cycles", 32'(cyc - c0), 32'd1);
      issue(1'b1, 1'b0, 32'd10, 32'h0);
      #3;
      chk("t6_rd10", bus.rdata, 32'd43);

      @(negedge clk);
      @(negedge clk);
      #3;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
